// File: rtl/key_expand.sv
// key_expand: iterative AES-128 key-schedule generator.
// Takes the cipher key from the register-file key port and emits round keys
// 0..NR in order, one per rk_valid/rk_ready handshake. Each round key is
// computed on the fly from the previous one, so no schedule is stored.
module key_expand #(
    parameter int W_KEY = 128,
    parameter int NR    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_KEY-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [W_KEY-1:0] rk,
    output logic [3:0]       rk_idx,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box computed as multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the affine transform. Avoids a hand-typed 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [W_KEY-1:0] r_rk;
    logic [W_KEY-1:0] w_rk_next;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_next;
    logic [7:0]       r_rcon;
    logic [7:0]       w_rcon_next;
    logic             r_valid;
    logic             w_valid_next;

    logic [31:0]      w_w0, w_w1, w_w2, w_w3;
    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [31:0]      w_t;
    logic [31:0]      w_n0, w_n1, w_n2, w_n3;
    logic [W_KEY-1:0] w_rk_round;
    logic [7:0]       w_rcon_xt;

    // Word split of the current round key; w0 is the most significant word.
    assign w_w0  = r_rk[127:96];
    assign w_w1  = r_rk[95:64];
    assign w_w2  = r_rk[63:32];
    assign w_w3  = r_rk[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    // SubWord: one S-box per byte lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
        assign w_sub[gi*8 +: 8] = sbox(w_rot[gi*8 +: 8]);
    end

    assign w_t        = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0       = w_w0 ^ w_t;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_rk_round = {w_n0, w_n1, w_n2, w_n3};
    assign w_rcon_xt  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // Next-state and datapath selection; everything holds unless a handshake
    // or a start from IDLE moves it.
    always_comb begin
        w_state_next = r_state;
        w_rk_next    = r_rk;
        w_idx_next   = r_idx;
        w_rcon_next  = r_rcon;
        w_valid_next = r_valid;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_rk_next    = key_in;
                    w_idx_next   = 4'd0;
                    w_rcon_next  = 8'h01;
                    w_valid_next = 1'b1;
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (r_valid && rk_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_valid_next = 1'b0;
                        w_state_next = DONE;
                    end else begin
                        w_rk_next   = w_rk_round;
                        w_idx_next  = r_idx + 4'd1;
                        w_rcon_next = w_rcon_xt;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rk    <= '0;
            r_idx   <= 4'd0;
            r_rcon  <= 8'h01;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rk    <= w_rk_next;
            r_idx   <= w_idx_next;
            r_rcon  <= w_rcon_next;
            r_valid <= w_valid_next;
        end
    end

    // Status outputs decode straight from registered state.
    assign busy     = (r_state == EMIT);
    assign done     = (r_state == DONE);
    assign rk_valid = r_valid;
    assign rk       = r_rk;
    assign rk_idx   = r_idx;

endmodule

// File: doc/key_expand.md
Name: key_expand

Overview:
- Iterative AES-128 key-schedule generator (FIPS-197 §5.2).
- Sits directly downstream of the register file: consumes the `key` read port (cipher key held in an xmm register) and emits round keys 0..10 in order, one per accepted handshake.
- Feeds the round/AddRoundKey datapath.
- Round keys are generated on the fly; no stored schedule.

Parameters:
- W_KEY, 128, key / round-key width in bits; only 128 supported.
- NR, 10, number of rounds; round keys emitted = NR+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request to expand key_in; sampled only in IDLE.
- key_in  in  W_KEY  cipher key from the register file `key` read port; bits [127:96] = w0, bytes big-endian.
- busy  out  1  high from the cycle after start is accepted until done.
- rk_valid  out  1  rk/rk_idx hold a valid round key.
- rk_ready  in  1  consumer accepts rk this cycle when rk_valid && rk_ready.
- rk  out  W_KEY  current round key, same word/byte layout as key_in.
- rk_idx  out  4  round index of rk, 0..NR.
- done  out  1  single-cycle pulse after round key NR is accepted.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - busy=0, rk_valid=0, done=0, rk=0, rk_idx=0, rcon=8'h01.
  - Takes effect immediately, including mid-expansion; the sequence is abandoned and never resumed.
- State machine: IDLE, EMIT, DONE.
- IDLE:
  - start=1 at edge N: capture key_in into rk, set rk_idx=0, rcon=8'h01, state=EMIT.
  - From cycle N+1: busy=1, rk_valid=1.
  - start=0: remain in IDLE.
- EMIT, rk_valid=1:
  - rk_valid && rk_ready && rk_idx<NR: rk <= next(rk, rcon), rk_idx <= rk_idx+1, rcon <= xtime(rcon), rk_valid stays 1.
  - rk_valid && rk_ready && rk_idx==NR: rk_valid <= 0, state=DONE.
  - rk_ready=0: rk, rk_idx and rcon hold stable (no change while valid and not accepted).
- DONE:
  - done=1 for exactly one cycle; busy=0 in that same cycle.
  - Next edge → IDLE.
  - start in DONE is ignored.
- start while busy or in DONE is ignored; key_in is not re-sampled.
- Latency and throughput:
  - First round key valid 1 cycle after start.
  - With rk_ready tied high: one round key per cycle, 11 cycles of rk_valid, done in the following cycle.
- next(rk, rcon), with w0..w3 = rk[127:96]..rk[31:0]:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - RotWord: {b1,b2,b3,b0}.
  - SubWord: four FIPS-197 S-box lookups, combinational within the block (ROM table or GF(2^8) inverse + affine; implementer's choice).
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - rcon wraps only via IDLE reload, never modulo.
- Output registering:
  - rk and rk_idx are registered outputs; no combinational path from rk_ready to rk.
  - rk_valid and done are registered; rk_ready may combinationally affect nothing but next state.
- Simultaneous rst=0 and start=1: reset wins; start lost.

Test Plan:
- FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle, rk_ready=1 → rk_idx0=2b7e…4f3c, rk_idx1=a0fafe1788542cb123a339392a6c7605, rk_idx10=d014f9a8c9ee2589e13f0cc8b6630ca6; 11 consecutive valid cycles, done pulse on 12th, busy low with done.
- Zero key: key_in=0 → rk_idx1=62636363626363636263636362636363, rk_idx2=9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
- Backpressure: A.1 key, rk_ready toggled 0/1 pseudo-randomly (incl. 5-cycle stall at idx 4) → rk stable during stalls, same 11 keys in order, done exactly once.
- Start while busy: second start with a different key at idx 3 → ignored, sequence completes with original key; start in DONE cycle also ignored.
- Reset mid-operation: rst=0 asynchronously at idx 6 → rk_valid/busy/done/rk/rk_idx=0 immediately; new start after release yields idx0 = new key and rcon restarted (idx1 correct).
- Back-to-back: start asserted in the cycle after done → new expansion accepted from IDLE, rk_idx restarts at 0.
